// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the 5-stage MIPS pipeline. It also detects load-use
// hazards, inserts one-cycle bubbles, and drives the PC and IF/ID write enables.
module id_ex_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [1:0]                id_alu_op,
  input  logic                      id_reg_dst,
  input  logic                      id_jump,
  input  logic                      id_branch,
  input  logic                      id_bne,
  input  logic                      id_mem_read,
  input  logic                      id_mem_to_reg,
  input  logic                      id_mem_write,
  input  logic                      id_alu_src,
  input  logic                      id_reg_write,
  input  logic [DATA_WIDTH-1:0]     id_pc_plus4,
  input  logic [DATA_WIDTH-1:0]     id_read_data1,
  input  logic [DATA_WIDTH-1:0]     id_read_data2,
  input  logic [DATA_WIDTH-1:0]     id_imm,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs,
  input  logic [REG_ADDR_WIDTH-1:0] id_rt,
  input  logic [REG_ADDR_WIDTH-1:0] id_rd,
  input  logic [5:0]                id_funct,
  input  logic                      flush,
  input  logic                      hold,
  output logic [1:0]                ex_alu_op,
  output logic                      ex_reg_dst,
  output logic                      ex_jump,
  output logic                      ex_branch,
  output logic                      ex_bne,
  output logic                      ex_mem_read,
  output logic                      ex_mem_to_reg,
  output logic                      ex_mem_write,
  output logic                      ex_alu_src,
  output logic                      ex_reg_write,
  output logic [DATA_WIDTH-1:0]     ex_pc_plus4,
  output logic [DATA_WIDTH-1:0]     ex_read_data1,
  output logic [DATA_WIDTH-1:0]     ex_read_data2,
  output logic [DATA_WIDTH-1:0]     ex_imm,
  output logic [REG_ADDR_WIDTH-1:0] ex_rs,
  output logic [REG_ADDR_WIDTH-1:0] ex_rt,
  output logic [REG_ADDR_WIDTH-1:0] ex_rd,
  output logic [5:0]                ex_funct,
  output logic                      ex_valid,
  output logic                      pc_write,
  output logic                      if_id_write,
  output logic [CNT_WIDTH-1:0]      bubble_count
);

  localparam int CTRL_W = 11;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [CTRL_W-1:0]         w_id_ctrl;
  logic                      w_load_use;
  logic                      w_stall;

  logic [CTRL_W-1:0]         r_ex_ctrl;
  logic [DATA_WIDTH-1:0]     r_ex_pc_plus4;
  logic [DATA_WIDTH-1:0]     r_ex_read_data1;
  logic [DATA_WIDTH-1:0]     r_ex_read_data2;
  logic [DATA_WIDTH-1:0]     r_ex_imm;
  logic [REG_ADDR_WIDTH-1:0] r_ex_rs;
  logic [REG_ADDR_WIDTH-1:0] r_ex_rt;
  logic [REG_ADDR_WIDTH-1:0] r_ex_rd;
  logic [5:0]                r_ex_funct;
  logic                      r_ex_valid;
  logic [CNT_WIDTH-1:0]      r_bubble_count;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_WIDTH'(1);
  endfunction

  assign w_id_ctrl = {id_alu_op, id_reg_dst, id_jump, id_branch, id_bne, id_mem_read,
                      id_mem_to_reg, id_mem_write, id_alu_src, id_reg_write};

  // Both rs and rt are compared for every instruction. This can stall when no stall is
  // needed, but it never misses a hazard.
  assign w_load_use = ex_mem_read & r_ex_valid & (r_ex_rt != '0) &
                      ((r_ex_rt == id_rs) | (r_ex_rt == id_rt));
  assign w_stall     = w_load_use | hold;
  assign pc_write    = ~w_stall;
  assign if_id_write = ~w_stall;

  // Stage boundary ID -> EX. Flush takes priority over hold, and hold over a bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ex_ctrl       <= '0;
      r_ex_pc_plus4   <= '0;
      r_ex_read_data1 <= '0;
      r_ex_read_data2 <= '0;
      r_ex_imm        <= '0;
      r_ex_rs         <= '0;
      r_ex_rt         <= '0;
      r_ex_rd         <= '0;
      r_ex_funct      <= '0;
      r_ex_valid      <= 1'b0;
      r_bubble_count  <= '0;
    end else if (flush || !hold) begin
      r_ex_pc_plus4   <= id_pc_plus4;
      r_ex_read_data1 <= id_read_data1;
      r_ex_read_data2 <= id_read_data2;
      r_ex_imm        <= id_imm;
      r_ex_rs         <= id_rs;
      r_ex_rt         <= id_rt;
      r_ex_rd         <= id_rd;
      r_ex_funct      <= id_funct;
      if (flush) begin
        r_ex_ctrl  <= '0;
        r_ex_valid <= 1'b0;
      end else if (w_load_use) begin
        r_ex_ctrl      <= '0;
        r_ex_valid     <= 1'b0;
        r_bubble_count <= sat_inc(r_bubble_count);
      end else begin
        r_ex_ctrl  <= w_id_ctrl;
        r_ex_valid <= 1'b1;
      end
    end
  end

  assign {ex_alu_op, ex_reg_dst, ex_jump, ex_branch, ex_bne, ex_mem_read,
          ex_mem_to_reg, ex_mem_write, ex_alu_src, ex_reg_write} = r_ex_ctrl;
  assign ex_pc_plus4   = r_ex_pc_plus4;
  assign ex_read_data1 = r_ex_read_data1;
  assign ex_read_data2 = r_ex_read_data2;
  assign ex_imm        = r_ex_imm;
  assign ex_rs         = r_ex_rs;
  assign ex_rt         = r_ex_rt;
  assign ex_rd         = r_ex_rd;
  assign ex_funct      = r_ex_funct;
  assign ex_valid      = r_ex_valid;
  assign bubble_count  = r_bubble_count;

endmodule
